// File: rtl/alu_scan_display.sv
// rtl/alu_scan_display.sv - registered ALU with synchronised load strobe and scanned hex 7-segment readout
module alu_scan_display #(
    parameter int WIDTH        = 8,
    parameter int DIG_BITS     = 3,
    parameter int REFRESH_BITS = 17,
    parameter int LZB          = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [2:0]               f,
    input  logic                     ld,
    output logic [WIDTH:0]           r,
    output logic                     zero,
    output logic                     ovf,
    output logic                     done,
    output logic [6:0]               a_to_g,
    output logic [2**DIG_BITS-1:0]   an,
    output logic                     dp
);
    localparam int NDIG = 2**DIG_BITS;
    localparam int USED = (WIDTH + 4) / 4;
    localparam int PW   = 4 * USED;
    localparam int CW   = REFRESH_BITS + DIG_BITS;

    logic             ld_s1_q, ld_s2_q, ld_prev_q, pend_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       f_q;
    logic [WIDTH:0]   r_q, r_d;
    logic             zero_q, ovf_q, ovf_d, done_q;
    logic [CW-1:0]    cnt_q;
    logic [6:0]       seg_q, seg_d;
    logic [NDIG-1:0]  an_q, an_d;
    logic             dp_q, dp_d;
    logic             ld_edge;

    assign ld_edge = ld_s2_q & ~ld_prev_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ld_s1_q   <= 1'b0;
            ld_s2_q   <= 1'b0;
            ld_prev_q <= 1'b0;
            pend_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            f_q       <= '0;
            r_q       <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ld_s1_q   <= ld;
            ld_s2_q   <= ld_s1_q;
            ld_prev_q <= ld_s2_q;
            // Capture and result stages are independent so back-to-back edges are never merged
            pend_q    <= ld_edge;
            if (ld_edge) begin
                a_q <= a;
                b_q <= b;
                f_q <= f;
            end
            done_q <= pend_q;
            if (pend_q) begin
                r_q    <= r_d;
                zero_q <= (r_d == '0);
                ovf_q  <= ovf_d;
            end
        end
    end

    always_comb begin
        logic [WIDTH:0] ax, bx;
        ax    = {1'b0, a_q};
        bx    = {1'b0, b_q};
        r_d   = '0;
        ovf_d = 1'b0;
        case (f_q)
            3'b000: r_d = ax & bx;
            3'b001: r_d = ax | bx;
            3'b010: begin
                r_d   = ax + bx;
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b011: begin
                r_d   = ax - bx;
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (r_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b100: r_d = ax ^ bx;
            3'b101: r_d = {1'b0, ~a_q};
            3'b110: r_d = {{WIDTH{1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: r_d = bx;
        endcase
    end

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'h01;  4'h1: hex_font = 7'h4F;
            4'h2: hex_font = 7'h12;  4'h3: hex_font = 7'h06;
            4'h4: hex_font = 7'h4C;  4'h5: hex_font = 7'h24;
            4'h6: hex_font = 7'h20;  4'h7: hex_font = 7'h0F;
            4'h8: hex_font = 7'h00;  4'h9: hex_font = 7'h04;
            4'hA: hex_font = 7'h08;  4'hB: hex_font = 7'h60;
            4'hC: hex_font = 7'h31;  4'hD: hex_font = 7'h42;
            4'hE: hex_font = 7'h30;  default: hex_font = 7'h38;
        endcase
    endfunction

    always_comb begin
        logic [DIG_BITS-1:0] idx;
        logic [PW-1:0]       r_pad;
        logic [3:0]          nib;
        logic                on;
        int                  msd;
        idx   = cnt_q[CW-1 -: DIG_BITS];
        r_pad = PW'(r_q);
        nib   = 4'h0;
        msd   = 0;
        for (int k = 0; k < USED; k++) begin
            if (r_pad[4*k +: 4] != 4'h0) msd = k;
            if (int'(idx) == k) nib = r_pad[4*k +: 4];
        end
        // Digit 0 is always lit; higher digits obey leading-zero blanking
        on    = (int'(idx) < USED) && ((LZB == 0) || (int'(idx) <= msd));
        an_d  = on ? ~(NDIG'(1) << idx) : '1;
        seg_d = on ? hex_font(nib) : 7'h7F;
        dp_d  = ~(on && (idx == '0) && ovf_q);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
            seg_q <= 7'h7F;
            an_q  <= '1;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign r      = r_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;
    assign done   = done_q;
    assign a_to_g = seg_q;
    assign an     = an_q;
    assign dp     = dp_q;
endmodule

// File: tb/tb_alu_scan_display.sv
// tb/tb_alu_scan_display.sv - randomized self-checking bench for alu_scan_display against a behavioural model
module tb_alu_scan_display;
    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] a, b;
    logic [2:0] f;
    logic       ld;
    logic [8:0] r;
    logic       zero, ovf, done;
    logic [6:0] a_to_g;
    logic [7:0] an;
    logic       dp;

    int checks = 0;
    int errors = 0;

    logic [6:0] font [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    alu_scan_display #(.WIDTH(8), .DIG_BITS(3), .REFRESH_BITS(2), .LZB(1)) dut (
        .clk(clk), .clr(clr), .a(a), .b(b), .f(f), .ld(ld),
        .r(r), .zero(zero), .ovf(ovf), .done(done),
        .a_to_g(a_to_g), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] fv,
                                  output logic [8:0] rr, output logic zz, output logic oo);
        int sa, sb, ua, ub, res;
        sa = $signed(av);
        sb = $signed(bv);
        ua = av;
        ub = bv;
        oo = 1'b0;
        case (fv)
            3'd0: res = ua & ub;
            3'd1: res = ua | ub;
            3'd2: begin res = ua + ub; oo = (sa + sb > 127) || (sa + sb < -128); end
            3'd3: begin res = ua - ub; oo = (sa - sb > 127) || (sa - sb < -128); end
            3'd4: res = ua ^ ub;
            3'd5: res = 255 - ua;
            3'd6: res = (sa < sb) ? 1 : 0;
            default: res = ub;
        endcase
        rr = 9'(res);
        zz = (rr == 9'd0);
    endfunction

    task automatic do_load(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] fv,
                           output logic got, output logic [8:0] rr, output logic zz,
                           output logic oo, output int width);
        got = 1'b0; rr = '0; zz = 1'b0; oo = 1'b0; width = 0;
        @(negedge clk);
        a = av; b = bv; f = fv; ld = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; rr = r; zz = zero; oo = ovf;
                break;
            end
        end
        if (got) begin
            @(negedge clk);
            width = done ? 2 : 1;
        end
        ld = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_display(input logic [8:0] er, input logic eo, input string nm);
        logic [11:0] pad;
        logic [7:0]  seen;
        int msd, k;
        pad  = {3'b000, er};
        seen = '0;
        msd  = 0;
        for (int j = 0; j < 3; j++) if (pad[4*j +: 4] != 4'h0) msd = j;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            checks++;
            if (an == 8'hFF) begin
                if (dp !== 1'b1) begin
                    errors++; $display("FAIL %s dark dp: got %b want 1", nm, dp);
                end
                continue;
            end
            k = 0;
            for (int i = 0; i < 8; i++) if (!an[i]) k = i;
            if ($countones(~an) != 1 || k > msd) begin
                errors++; $display("FAIL %s an: got %h, lit digits allowed 0..%0d", nm, an, msd);
                continue;
            end
            seen[k] = 1'b1;
            checks++;
            if (a_to_g !== font[pad[4*k +: 4]]) begin
                errors++; $display("FAIL %s seg digit %0d: got %h want %h", nm, k, a_to_g, font[pad[4*k +: 4]]);
            end
            checks++;
            if (dp !== !(k == 0 && eo)) begin
                errors++; $display("FAIL %s dp digit %0d: got %b want %b", nm, k, dp, !(k == 0 && eo));
            end
        end
        for (int j = 0; j <= msd; j++) begin
            checks++;
            if (!seen[j]) begin
                errors++; $display("FAIL %s digit %0d never shown: got 0 want 1", nm, j);
            end
        end
    endtask

    task automatic test_add_carry();
        logic got, zz, oo; logic [8:0] rr; int w;
        do_load(8'hFF, 8'h01, 3'b010, got, rr, zz, oo, w);
        checks++;
        if (!got || rr !== 9'h100 || zz !== 1'b0 || oo !== 1'b0 || w != 1) begin
            errors++; $display("FAIL add_carry: got done=%b r=%h z=%b o=%b w=%0d want 1 100 0 0 1", got, rr, zz, oo, w);
        end
        test_display(9'h100, 1'b0, "add_carry_disp");
    endtask

    task automatic test_reset();
        repeat (13) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        checks++;
        if (r !== 9'h0 || zero !== 1'b0 || ovf !== 1'b0 || done !== 1'b0 ||
            a_to_g !== 7'h7F || an !== 8'hFF || dp !== 1'b1) begin
            errors++; $display("FAIL reset_vals: got r=%h z=%b o=%b d=%b seg=%h an=%h dp=%b", r, zero, ovf, done, a_to_g, an, dp);
        end
        @(negedge clk);
        clr = 1'b0;
        begin
            logic found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (an !== 8'hFF) begin found = 1'b1; break; end
            end
            checks++;
            if (!found || an !== 8'hFE) begin
                errors++; $display("FAIL reset_first_digit: got an=%h want fe", an);
            end
        end
    endtask

    task automatic test_sub_zero();
        logic got, zz, oo; logic [8:0] rr; int w;
        do_load(8'h05, 8'h05, 3'b011, got, rr, zz, oo, w);
        checks++;
        if (!got || rr !== 9'h000 || zz !== 1'b1 || oo !== 1'b0) begin
            errors++; $display("FAIL sub_zero: got done=%b r=%h z=%b o=%b want 1 000 1 0", got, rr, zz, oo);
        end
        test_display(9'h000, 1'b0, "sub_zero_disp");
    endtask

    task automatic test_ovf();
        logic got, zz, oo; logic [8:0] rr; int w;
        do_load(8'h7F, 8'h01, 3'b010, got, rr, zz, oo, w);
        checks++;
        if (!got || rr !== 9'h080 || zz !== 1'b0 || oo !== 1'b1) begin
            errors++; $display("FAIL add_ovf: got done=%b r=%h z=%b o=%b want 1 080 0 1", got, rr, zz, oo);
        end
        test_display(9'h080, 1'b1, "add_ovf_disp");
    endtask

    task automatic test_slt_sub();
        logic got, zz, oo; logic [8:0] rr; int w;
        do_load(8'h80, 8'h01, 3'b110, got, rr, zz, oo, w);
        checks++;
        if (!got || rr !== 9'h001 || oo !== 1'b0) begin
            errors++; $display("FAIL slt: got done=%b r=%h o=%b want 1 001 0", got, rr, oo);
        end
        do_load(8'h00, 8'h01, 3'b011, got, rr, zz, oo, w);
        checks++;
        if (!got || rr !== 9'h1FF || zz !== 1'b0 || oo !== 1'b0) begin
            errors++; $display("FAIL sub_borrow: got done=%b r=%h z=%b o=%b want 1 1ff 0 0", got, rr, zz, oo);
        end
    endtask

    task automatic test_random();
        logic got, zz, oo, ez, eo; logic [8:0] rr, er; int w;
        logic [7:0] av, bv; logic [2:0] fv;
        for (int n = 0; n < 40; n++) begin
            av = 8'($urandom); bv = 8'($urandom); fv = 3'($urandom_range(0, 7));
            if (n % 8 == 0) bv = av;
            model(av, bv, fv, er, ez, eo);
            do_load(av, bv, fv, got, rr, zz, oo, w);
            checks++;
            if (!got || rr !== er || zz !== ez || oo !== eo || w != 1) begin
                errors++; $display("FAIL random a=%h b=%h f=%0d: got done=%b r=%h z=%b o=%b w=%0d want r=%h z=%b o=%b w=1",
                                   av, bv, fv, got, rr, zz, oo, w, er, ez, eo);
            end
        end
        test_display(er, eo, "random_disp");
    endtask

    task automatic test_ld_held();
        int pulses = 0;
        @(negedge clk);
        a = 8'h12; b = 8'h34; f = 3'b001; ld = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        ld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL ld_held pulses: got %0d want 1", pulses);
        end
        checks++;
        if (r !== 9'h036) begin
            errors++; $display("FAIL ld_held r: got %h want 036", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] expq[$];
        logic [8:0] er; logic ez, eo;
        int pulses = 0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); f = 3'($urandom_range(0, 7)); ld = 1'b1;
            model(a, b, f, er, ez, eo);
            expq.push_back(er);
            for (int c = 0; c < 6; c++) begin
                if (c == 2) begin @(negedge clk); ld = 1'b0; end
                else @(negedge clk);
                if (done) begin
                    pulses++;
                    checks++;
                    if (expq.size() == 0) begin
                        errors++; $display("FAIL b2b extra done: got r=%h want no pulse", r);
                    end else begin
                        er = expq.pop_front();
                        if (r !== er) begin
                            errors++; $display("FAIL b2b r: got %h want %h", r, er);
                        end
                    end
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL b2b extra done: got r=%h want no pulse", r);
                end else begin
                    er = expq.pop_front();
                    if (r !== er) begin
                        errors++; $display("FAIL b2b r: got %h want %h", r, er);
                    end
                end
            end
        end
        checks++;
        if (pulses != 6) begin
            errors++; $display("FAIL b2b pulses: got %0d want 6", pulses);
        end
    endtask

    initial begin
        clr = 1'b1; ld = 1'b0; a = '0; b = '0; f = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (r !== 9'h0 || done !== 1'b0 || an !== 8'hFF || a_to_g !== 7'h7F || dp !== 1'b1) begin
            errors++; $display("FAIL init_reset: got r=%h d=%b an=%h seg=%h dp=%b", r, done, an, a_to_g, dp);
        end
        clr = 1'b0;
        test_add_carry();
        test_reset();
        test_sub_zero();
        test_ovf();
        test_slt_sub();
        test_random();
        test_ld_held();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
